multicycle_datapath: RTL
========================

# multicycle_datapath

Parametrised multi-cycle MIPS-subset processor core: datapath plus control FSM in one block. It uses a single shared instruction/data memory port with a ready handshake, so memories with wait states are supported. It is the successor to the single-cycle datapath. It reuses one ALU and one memory port across cycles, and it adds jump, addi, illegal-instruction halt and a debug register read port.

## Interface
Parameters:
- ADDR_W, 32, memory/PC byte-address width (8..32); PC and addresses wrap modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset (word aligned).

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Res  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  byte address; memory ignores [1:0].
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, sampled on the edge where mem_ready=1.
- mem_ready  in  1  transfer completes on the rising edge where mem_req=1 and mem_ready=1.
- halt  out  1  core stopped on an illegal instruction.
- pc  out  ADDR_W  current PC.
- instr  out  32  instruction register.
- state  out  3  FSM state encoding (debug).
- dbg_addr  in  5  register-file debug read index.
- dbg_data  out  32  combinational read of rf[dbg_addr]; reads 0 for index 0.

## Operation
- Instructions and encodings:
  - R-type, op 000000, funct add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed).
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
  - Any other op or funct is illegal and moves the core to HALT.
- State encodings: IDLE=6, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- IDLE: entered on reset. Moves to FETCH on the next edge.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready, IR<=mem_rdata and pc<=pc+4, then DECODE.
- DECODE:
  - A<=rf[rs], B<=rf[rt].
  - TGT<=pc+(sext(imm)<<2), where pc is already incremented.
  - Illegal instruction: HALT. Otherwise EXEC.
- EXEC:
  - R-type: ALUOUT<=A op B, then WB.
  - addi: ALUOUT<=A+sext(imm), then WB.
  - lw/sw: ALUOUT<=A+sext(imm), then MEM.
  - beq: if A==B then pc<=TGT. Then FETCH.
  - j: pc<={pc[ADDR_W-1:28], instr[25:0], 2'b00}, truncated to ADDR_W. Then FETCH.
- MEM: mem_req=1, mem_addr=ALUOUT[ADDR_W-1:0], mem_we=1 for sw, mem_wdata=B. On ready, sw goes to FETCH; lw does MDR<=mem_rdata and goes to WB.
- WB: writes rf[rd] for R-type, rf[rt] for addi, and MDR into rf[rt] for lw. Then FETCH. Writes to register 0 are discarded.
- HALT: mem_req=0 and halt=1. Stays in HALT until reset.
- Arithmetic: 32-bit two's complement. Overflow is ignored, with no trap.

## Timing
- Reset (Res=0, asynchronous) sets:
  - state=IDLE, pc=RESET_PC, IR=0, A=B=ALUOUT=MDR=TGT=0.
  - All 32 registers = 0.
  - halt=0, mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0.
- Outputs: mem_req, mem_we and mem_addr are decoded combinationally from registered state.
- Handshake:
  - While mem_req=1 and mem_ready=0, the state holds and mem_addr, mem_we and mem_wdata stay stable.
  - mem_ready is ignored when mem_req=0.
- Cycles per instruction with zero wait states: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.
- Register-file write takes effect on the WB edge. The next instruction's DECODE reads the new value.
- Reset asserted mid-transfer aborts it: mem_req drops asynchronously, and no register or PC update from the aborted instruction takes effect.

## Test plan
- Reset and fetch:
  - Stimulus: hold Res=0 with RESET_PC=0, then release.
  - Required: during reset pc=0 and mem_req=0. After release, one IDLE cycle, then FETCH with mem_req=1 and mem_addr=0.
- ALU path, mem_ready tied high:
  - Stimulus: 0x20010005 (addi $1,$0,5), then 0x00211020 (add $2,$1,$1).
  - Required: dbg rf[1]=5, rf[2]=10. The add takes exactly 4 cycles. 0x20000007 (addi $0,$0,7) leaves rf[0]=0.
- Memory with wait states:
  - Stimulus: 0xAC020008 (sw $2,8($0)), then 0x8C030008 (lw $3,8($0)). mem_ready is held low 3 cycles in each MEM state.
  - Required: mem_addr=8, mem_we and mem_wdata=10 stay stable throughout. rf[3]=10. The lw takes 8 cycles.
- Control flow:
  - Stimulus and required: 0x10210002 (beq $1,$1,2) at pc 0x10 gives next fetch at 0x1C. With $1≠$2, 0x10220002 (beq $1,$2,2) gives 0x14. 0x08000010 (j 0x40) gives next fetch at 0x40.
- Illegal instruction:
  - Stimulus: 0xFC000000.
  - Required: DECODE goes to HALT with halt=1 and mem_req=0, holding 20 cycles. After a reset pulse, halt=0 and pc=RESET_PC.
- Reset mid-MEM:
  - Stimulus: during an sw with mem_ready=0, assert Res=0.
  - Required: mem_req falls without waiting for a clock edge, pc=RESET_PC, and the memory model records no write.

Source files
------------

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq, addi, j).
//   One ALU and one shared instruction/data memory port are reused across
//   the FETCH/DECODE/EXEC/MEM/WB states. Any undecodable instruction parks
//   the core in HALT until reset.
// Ports
//   Clk        : clock, rising edge
//   Res        : asynchronous active-low reset
//   mem_req    : memory request (FETCH and MEM states)
//   mem_we     : write enable, valid while mem_req
//   mem_addr   : byte address (pc in FETCH, ALUOUT in MEM)
//   mem_wdata  : store data (B register)
//   mem_rdata  : read data, taken on the edge where mem_ready=1
//   mem_ready  : completes a transfer when mem_req=1
//   halt       : core stopped on an illegal instruction
//   pc, instr, state : debug views of PC, IR and FSM state
//   dbg_addr / dbg_data : combinational register-file read port
module multicycle_datapath #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              Clk,
    input  logic              Res,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic [2:0]        state,
    input  logic [4:0]        dbg_addr,
    output logic [31:0]       dbg_data
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_IDLE   = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // True when the instruction word belongs to the supported subset.
    function automatic logic is_legal(input logic [31:0] ir);
        logic ok;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:                                ok = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // R-type ALU operation selected by funct; slt compares signed.
    function automatic logic [31:0] alu_r(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (fn)
            FN_ADD:  r = a + b;
            FN_SUB:  r = a - b;
            FN_AND:  r = a & b;
            FN_OR:   r = a | b;
            FN_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
    logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]       aluout_q, aluout_d, mdr_q, mdr_d;
    logic [31:0]       rf_q [32];

    logic              rf_we_s;
    logic [4:0]        rf_waddr_s;
    logic [31:0]       rf_wdata_s;
    logic [31:0]       imm_s, boff_s, pc32_s, jtgt_s;
    logic              unused_s;

    assign imm_s  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign boff_s = imm_s << 2;
    assign pc32_s = 32'(pc_q);
    // j keeps the top PC nibble (when the address is that wide) and takes
    // the 26-bit word index from the instruction.
    assign jtgt_s = {pc32_s[31:28], ir_q[25:0], 2'b00};
    // shamt is not used by the supported R-type operations.
    assign unused_s = ^ir_q[10:6];

    // Next-state and datapath register update logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        aluout_d   = aluout_q;
        mdr_d      = mdr_q;
        tgt_d      = tgt_q;
        rf_we_s    = 1'b0;
        rf_waddr_s = 5'd0;
        rf_wdata_s = 32'd0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(32'd4);
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                a_d   = rf_q[ir_q[25:21]];
                b_d   = rf_q[ir_q[20:16]];
                tgt_d = pc_q + boff_s[ADDR_W-1:0];
                if (is_legal(ir_q)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (ir_q[31:26])
                    OP_RTYPE: begin
                        aluout_d = alu_r(ir_q[5:0], a_q, b_q);
                        state_d  = ST_WB;
                    end
                    OP_ADDI: begin
                        aluout_d = a_q + imm_s;
                        state_d  = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        aluout_d = a_q + imm_s;
                        state_d  = ST_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = tgt_q;
                        end else begin
                            pc_d = pc_q;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_J: begin
                        pc_d    = jtgt_s[ADDR_W-1:0];
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (ir_q[31:26] == OP_SW) begin
                        state_d = ST_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = ST_WB;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                case (ir_q[31:26])
                    OP_RTYPE: begin
                        rf_we_s    = 1'b1;
                        rf_waddr_s = ir_q[15:11];
                        rf_wdata_s = aluout_q;
                    end
                    OP_ADDI: begin
                        rf_we_s    = 1'b1;
                        rf_waddr_s = ir_q[20:16];
                        rf_wdata_s = aluout_q;
                    end
                    OP_LW: begin
                        rf_we_s    = 1'b1;
                        rf_waddr_s = ir_q[20:16];
                        rf_wdata_s = mdr_q;
                    end
                    default: rf_we_s = 1'b0;
                endcase
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // State, datapath registers and register file.
    always_ff @(posedge Clk or negedge Res) begin
        if (!Res) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
            mdr_q    <= 32'd0;
            tgt_q    <= {ADDR_W{1'b0}};
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            tgt_q    <= tgt_d;
            // Register 0 is hard-wired to zero, so its writes are dropped.
            if (rf_we_s && (rf_waddr_s != 5'd0)) begin
                rf_q[rf_waddr_s] <= rf_wdata_s;
            end
        end
    end

    // Memory port decoded from registered state so reset drops it at once.
    assign mem_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign mem_we    = (state_q == ST_MEM) && (ir_q[31:26] == OP_SW);
    assign mem_addr  = (state_q == ST_MEM) ? aluout_q[ADDR_W-1:0] : pc_q;
    assign mem_wdata = b_q;
    assign halt      = (state_q == ST_HALT);
    assign pc        = pc_q;
    assign instr     = ir_q;
    assign state     = state_q;
    assign dbg_data  = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

endmodule
